// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard unit and its HI/LO sequencer.
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_WB = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;
  localparam int NUM_SRC         = 2;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] x, input logic [4:0] y);
    return (x == y) && (x != 5'd0);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit bundle: stage register info in, stall/flush/forward out.
interface hazard_ctrl_if;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_WB;
  logic       we_reg_E, we_reg_M, we_reg_WB;
  logic       dm2reg_E, dm2reg_M;
  logic       branch_D, reg_jump_D, jump_D, pc_src_D;
  logic       md_start_E, md_is_div_E, hilo_rd_D;
  logic       stall_F, stall_D, stall_E;
  logic       flush_D, flush_E, flush_M;
  logic       fwd_a_D, fwd_b_D;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic       md_busy, hilo_we;

  modport master (
    output rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_WB,
           we_reg_E, we_reg_M, we_reg_WB, dm2reg_E, dm2reg_M,
           branch_D, reg_jump_D, jump_D, pc_src_D,
           md_start_E, md_is_div_E, hilo_rd_D,
    input  stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
           fwd_a_D, fwd_b_D, fwd_a_E, fwd_b_E, md_busy, hilo_we
  );

  modport slave (
    input  rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_WB,
           we_reg_E, we_reg_M, we_reg_WB, dm2reg_E, dm2reg_M,
           branch_D, reg_jump_D, jump_D, pc_src_D,
           md_start_E, md_is_div_E, hilo_rd_D,
    output stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
           fwd_a_D, fwd_b_D, fwd_a_E, fwd_b_E, md_busy, hilo_we
  );
endinterface

// File: rtl/hazard_ctrl_md_sequencer.sv
// HI/LO occupancy sequencer: counts mult/div latency and strobes hilo_we once on completion.
module md_sequencer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy,
  output logic hilo_we
);
  md_state_t  state;
  logic [5:0] cnt, lat;

  assign lat = md_is_div ? 6'(DIV_CYCLES - 1) : 6'(MULT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      hilo_we <= 1'b0;
    end else begin
      case (state)
        IDLE: if (md_start) begin
          state   <= BUSY;
          cnt     <= lat;
          md_busy <= 1'b1;
        end
        // A start seen here is the next op held in E; it is picked up in DONE.
        BUSY: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state   <= DONE;
            md_busy <= 1'b0;
            hilo_we <= 1'b1;
          end
        end
        DONE: begin
          hilo_we <= 1'b0;
          if (md_start) begin
            state   <= BUSY;
            cnt     <= lat;
            md_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          md_busy <= 1'b0;
          hilo_we <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load/branch/HI-LO stalls and flushes.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  logic [NUM_SRC-1:0][4:0] src_D, src_E;
  logic [NUM_SRC-1:0][1:0] fwd_E;
  logic [NUM_SRC-1:0]      fwd_D;
  logic hit_E, hit_M, lw_stall, br_stall, hilo_stall, md_conflict;
  logic md_busy, stall;

  assign src_D = {hz.rt_D, hz.rs_D};
  assign src_E = {hz.rt_E, hz.rs_E};

  // Index 0 is operand A (rs), index 1 is operand B (rt); M beats WB.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign fwd_E[i] = (hz.we_reg_M  && reg_match(hz.wa_M,  src_E[i])) ? FWD_M  :
                      (hz.we_reg_WB && reg_match(hz.wa_WB, src_E[i])) ? FWD_WB : FWD_RF;
    assign fwd_D[i] = hz.we_reg_M && reg_match(hz.wa_M, src_D[i]);
  end

  assign hz.fwd_a_E = fwd_E[0];
  assign hz.fwd_b_E = fwd_E[1];
  assign hz.fwd_a_D = fwd_D[0];
  assign hz.fwd_b_D = fwd_D[1];

  assign hit_E = reg_match(hz.wa_E, hz.rs_D) | reg_match(hz.wa_E, hz.rt_D);
  assign hit_M = reg_match(hz.wa_M, hz.rs_D) | reg_match(hz.wa_M, hz.rt_D);

  assign lw_stall    = hz.dm2reg_E & hz.we_reg_E & hit_E;
  assign br_stall    = (hz.branch_D | hz.reg_jump_D) &
                       ((hz.we_reg_E & hit_E) | (hz.dm2reg_M & hit_M));
  assign hilo_stall  = md_busy & hz.hilo_rd_D;
  assign md_conflict = md_busy & hz.md_start_E;

  // Everything stall/flush is masked while reset is held.
  assign stall      = rst & (lw_stall | br_stall | hilo_stall | md_conflict);
  assign hz.stall_F = stall;
  assign hz.stall_D = stall;
  assign hz.stall_E = rst & md_conflict;
  assign hz.flush_M = rst & md_conflict;
  assign hz.flush_E = rst & (lw_stall | br_stall | hilo_stall) & ~md_conflict;
  assign hz.flush_D = rst & (hz.pc_src_D | hz.jump_D | hz.reg_jump_D) & ~stall;

  md_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .md_start  (hz.md_start_E),
    .md_is_div (hz.md_is_div_E),
    .md_busy   (md_busy),
    .hilo_we   (hz.hilo_we)
  );

  assign hz.md_busy = md_busy;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MULT_CYCLES=4, DIV_CYCLES=32).
module tb_hazard_ctrl;
  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;
  exp_t sb[$];

  hazard_ctrl_if hz();

  hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  // {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M}
  logic [5:0] sf;
  logic [7:0] md;
  assign sf = {hz.stall_F, hz.stall_D, hz.stall_E, hz.flush_D, hz.flush_E, hz.flush_M};
  assign md = {hz.md_busy, hz.hilo_we, sf};

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errs++;
      $error("FAIL sb_empty: observed %0h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errs++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz.rs_D = 0; hz.rt_D = 0; hz.rs_E = 0; hz.rt_E = 0;
    hz.wa_E = 0; hz.wa_M = 0; hz.wa_WB = 0;
    hz.we_reg_E = 0; hz.we_reg_M = 0; hz.we_reg_WB = 0;
    hz.dm2reg_E = 0; hz.dm2reg_M = 0;
    hz.branch_D = 0; hz.reg_jump_D = 0; hz.jump_D = 0; hz.pc_src_D = 0;
    hz.md_start_E = 0; hz.md_is_div_E = 0; hz.hilo_rd_D = 0;
  endtask

  initial begin
    // Reset held: hazards present but all stall/flush low; forwarding still live.
    clr();
    hz.dm2reg_E = 1; hz.we_reg_E = 1; hz.wa_E = 5; hz.rs_D = 5;
    hz.we_reg_M = 1; hz.wa_M = 3; hz.rs_E = 3;
    push("rst_md_sf", 16'h00);
    push("rst_fwd_a_E", 16'd2);
    #2;
    chk(16'(md));
    chk(16'(hz.fwd_a_E));
    tick(); tick();
    rst = 1'b1;
    clr();
    #1;

    // Load-use on rs and rt, plus non-hazard variants
    hz.dm2reg_E = 1; hz.we_reg_E = 1; hz.wa_E = 5; hz.rs_D = 5;
    push("load_use_rs", 16'b110010); #1; chk(16'(sf));
    hz.rs_D = 0; hz.rt_D = 5;
    push("load_use_rt", 16'b110010); #1; chk(16'(sf));
    hz.wa_E = 0; hz.rt_D = 0;
    push("load_use_r0", 16'b000000); #1; chk(16'(sf));
    hz.wa_E = 5; hz.rs_D = 5; hz.we_reg_E = 0;
    push("load_no_we", 16'b000000); #1; chk(16'(sf));
    clr();

    // Execute forwarding priority
    hz.we_reg_M = 1; hz.we_reg_WB = 1; hz.wa_M = 7; hz.wa_WB = 7; hz.rs_E = 7;
    push("fwd_a_M", 16'd2); #1; chk(16'(hz.fwd_a_E));
    hz.wa_M = 0;
    push("fwd_a_WB", 16'd1); #1; chk(16'(hz.fwd_a_E));
    hz.rs_E = 0;
    push("fwd_a_RF", 16'd0); #1; chk(16'(hz.fwd_a_E));
    clr();
    hz.we_reg_WB = 1; hz.wa_WB = 9; hz.wa_M = 9; hz.rt_E = 9;
    push("fwd_b_WB", 16'd1); #1; chk(16'(hz.fwd_b_E));
    clr();

    // Decode comparator forwarding
    hz.we_reg_M = 1; hz.wa_M = 4; hz.rs_D = 4; hz.rt_D = 4;
    push("fwd_D_ab", 16'b11); #1; chk(16'({hz.fwd_a_D, hz.fwd_b_D}));
    hz.rt_D = 0;
    push("fwd_D_a", 16'b10); #1; chk(16'({hz.fwd_a_D, hz.fwd_b_D}));
    clr();

    // Branch hazards: stalled branch must not flush D
    hz.branch_D = 1; hz.pc_src_D = 1; hz.we_reg_E = 1; hz.wa_E = 6; hz.rt_D = 6;
    push("br_stall_E", 16'b110010); #1; chk(16'(sf));
    clr();
    hz.reg_jump_D = 1; hz.dm2reg_M = 1; hz.wa_M = 6; hz.rs_D = 6;
    push("br_stall_M", 16'b110010); #1; chk(16'(sf));
    clr();
    hz.we_reg_E = 1; hz.wa_E = 6; hz.rs_D = 6;
    push("alu_no_branch", 16'b000000); #1; chk(16'(sf));
    clr();
    hz.jump_D = 1;
    push("jump_flush", 16'b000100); #1; chk(16'(sf));
    clr();

    // Divide: 31 busy cycles, hilo_we on cycle 32, then idle
    tick();
    hz.md_start_E = 1; hz.md_is_div_E = 1;
    for (int k = 0; k < 31; k++) push("div_busy", 16'h80);
    push("div_done", 16'h40);
    push("div_idle", 16'h00);
    tick();
    clr();
    #1;
    for (int k = 0; k < 33; k++) begin chk(16'(md)); tick(); end

    // Multiply with mfhi/mflo waiting in decode
    hz.md_start_E = 1;
    push("mul_start", 16'h00); #1; chk(16'(md));
    tick();
    hz.md_start_E = 0; hz.hilo_rd_D = 1;
    for (int k = 0; k < 3; k++) push("mul_hilo_stall", 16'hB2);
    push("mul_hilo_done", 16'h40);
    push("mul_hilo_idle", 16'h00);
    #1;
    for (int k = 0; k < 5; k++) begin chk(16'(md)); tick(); end
    clr();

    // Back-to-back: divide held in E behind a multiply, then reloaded
    hz.md_start_E = 1;
    tick();
    hz.md_is_div_E = 1;
    for (int k = 0; k < 3; k++) push("b2b_conflict", 16'hB9);
    push("b2b_done", 16'h40);
    #1;
    for (int k = 0; k < 4; k++) begin chk(16'(md)); tick(); end
    clr();
    for (int k = 0; k < 31; k++) push("b2b_div_busy", 16'h80);
    push("b2b_div_done", 16'h40);
    push("b2b_idle", 16'h00);
    #1;
    for (int k = 0; k < 33; k++) begin chk(16'(md)); tick(); end

    // Reset at cnt=10 of a divide: busy drops at once, no hilo_we afterwards
    hz.md_start_E = 1; hz.md_is_div_E = 1;
    tick();
    clr();
    for (int k = 0; k < 21; k++) tick();
    push("pre_rst_busy", 16'h80); chk(16'(md));
    rst = 1'b0;
    push("rst_async", 16'h00); #1; chk(16'(md));
    tick(); tick();
    rst = 1'b1;
    for (int k = 0; k < 34; k++) push("post_rst_idle", 16'h00);
    #1;
    for (int k = 0; k < 34; k++) begin chk(16'(md)); tick(); end

    // Taken branch with no hazard flushes decode
    hz.branch_D = 1; hz.pc_src_D = 1; hz.rs_D = 3; hz.rt_D = 4;
    push("br_taken_flush", 16'b000100); #1; chk(16'(sf));
    clr();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
